// File: rtl/top_pwm_alt_if.sv
// Register bus for top_pwm_alt: byte address, write/read strobes and registered read data.
interface top_pwm_alt_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_en_i;
    logic          rd_en_i;
    logic [DW-1:0] rd_data_o;

    modport master (
        output addr_i,
        output wr_data_i,
        output wr_en_i,
        output rd_en_i,
        input  rd_data_o
    );

    modport slave (
        input  addr_i,
        input  wr_data_i,
        input  wr_en_i,
        input  rd_en_i,
        output rd_data_o
    );
endinterface

// File: rtl/top_pwm_alt.sv
// Register-configured PWM with shadowed period/duty, glitch-free update at the counter wrap.
// Optional output polarity register at 0x0C when PWM_ALT_POLARITY_EN is defined.
module top_pwm_alt #(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int WIDTH_PERIOD = 16,
    parameter int WIDTH_DUTY   = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    top_pwm_alt_if.slave  regs,
    output logic          pwm_out_o
);

    localparam logic [AW-1:0] A_CONFIG = AW'(8'h00);
    localparam logic [AW-1:0] A_STATUS = AW'(8'h04);
    localparam logic [AW-1:0] A_COUNT  = AW'(8'h08);
`ifdef PWM_ALT_POLARITY_EN
    localparam logic [AW-1:0] A_POL    = AW'(8'h0C);
`endif

    logic [WIDTH_PERIOD-1:0] r_per_sh;
    logic [WIDTH_PERIOD-1:0] r_per_act;
    logic [WIDTH_PERIOD-1:0] r_cnt;
    logic [WIDTH_DUTY-1:0]   r_duty_sh;
    logic [WIDTH_DUTY-1:0]   r_duty_act;
    logic                    r_cfg_err;
    logic                    r_upd_pend;
    logic                    r_pwm;
    logic [DW-1:0]           r_rd_data;

    logic [WIDTH_PERIOD-1:0] w_wr_per;
    logic [WIDTH_DUTY-1:0]   w_wr_duty;
    logic                    w_cfg_wr;
    logic                    w_cfg_ok;
    logic                    w_per_zero;
    logic                    w_wrap;
    logic                    w_load;
    logic                    w_pwm_raw;
    logic                    w_invert;
    logic [DW-1:0]           w_rd_mux;

    assign w_wr_per   = regs.wr_data_i[16 +: WIDTH_PERIOD];
    assign w_wr_duty  = regs.wr_data_i[0 +: WIDTH_DUTY];
    assign w_cfg_wr   = regs.wr_en_i && (regs.addr_i == A_CONFIG);
    assign w_cfg_ok   = DW'(w_wr_duty) <= DW'(w_wr_per);
    assign w_per_zero = (r_per_act == '0);
    assign w_wrap     = !w_per_zero && (r_cnt == r_per_act - WIDTH_PERIOD'(1));
    // Shadow moves to active at the wrap, or immediately when the PWM is idle.
    assign w_load     = r_upd_pend && (w_per_zero || w_wrap);
    assign w_pwm_raw  = !w_per_zero && (DW'(r_cnt) < DW'(r_duty_act));

`ifdef PWM_ALT_POLARITY_EN
    logic r_invert;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_invert <= 1'b0;
        end else if (regs.wr_en_i && (regs.addr_i == A_POL)) begin
            r_invert <= regs.wr_data_i[0];
        end
    end

    assign w_invert = r_invert;
`else
    assign w_invert = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (regs.addr_i)
            A_CONFIG: begin
                w_rd_mux[16 +: WIDTH_PERIOD] = r_per_sh;
                w_rd_mux[0 +: WIDTH_DUTY]    = r_duty_sh;
            end
            A_STATUS: begin
                w_rd_mux[1:0] = {r_upd_pend, r_cfg_err};
            end
            A_COUNT: begin
                w_rd_mux[WIDTH_PERIOD-1:0] = r_cnt;
            end
`ifdef PWM_ALT_POLARITY_EN
            A_POL: begin
                w_rd_mux[0] = r_invert;
            end
`endif
            default: begin
                w_rd_mux = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_per_sh   <= '0;
            r_duty_sh  <= '0;
            r_cfg_err  <= 1'b0;
            r_upd_pend <= 1'b0;
        end else if (w_cfg_wr) begin
            if (w_cfg_ok) begin
                r_per_sh   <= w_wr_per;
                r_duty_sh  <= w_wr_duty;
                r_cfg_err  <= 1'b0;
                r_upd_pend <= 1'b1;
            end else begin
                r_cfg_err  <= 1'b1;
                if (w_load) begin
                    r_upd_pend <= 1'b0;
                end
            end
        end else if (w_load) begin
            r_upd_pend <= 1'b0;
        end
    end

    // A write landing on the wrap clock sets pending again, so it waits for the next wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_per_act  <= '0;
            r_duty_act <= '0;
        end else if (w_load) begin
            r_per_act  <= r_per_sh;
            r_duty_act <= r_duty_sh;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_pwm_raw ^ w_invert;
            if (w_per_zero || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + WIDTH_PERIOD'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else if (regs.rd_en_i) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign regs.rd_data_o = r_rd_data;
    assign pwm_out_o      = r_pwm;

endmodule

// File: tb/tb_top_pwm_alt.sv
// Directed bench for top_pwm_alt: register access, waveform run lengths, shadow update, reset.
module tb_top_pwm_alt;

    logic clk;
    logic rst;
    logic pwm;
    int   total;
    int   bad;

    int   mon_run;
    bit   mon_prev;
    int   hi_len;
    int   lo_len;
    int   hi_done;
    int   lo_done;

    top_pwm_alt_if #(.AW(8), .DW(32)) bus_if ();

    top_pwm_alt dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .regs      (bus_if.slave),
        .pwm_out_o (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-length monitor sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (pwm === mon_prev) begin
            mon_run = mon_run + 1;
        end else begin
            if (mon_prev) begin
                hi_len  = mon_run;
                hi_done = hi_done + 1;
            end else begin
                lo_len  = mon_run;
                lo_done = lo_done + 1;
            end
            mon_run  = 1;
            mon_prev = pwm;
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.addr_i    = a;
        bus_if.wr_data_i = d;
        bus_if.wr_en_i   = 1'b1;
        @(posedge clk); #1;
        bus_if.wr_en_i   = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        bus_if.addr_i  = a;
        bus_if.rd_en_i = 1'b1;
        @(posedge clk); #1;
        bus_if.rd_en_i = 1'b0;
        d = bus_if.rd_data_o;
    endtask

    task automatic wait_hi(input int budget, output bit ok);
        int start;
        start = hi_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (hi_done != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_lo(input int budget, output bit ok);
        int start;
        start = lo_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (lo_done != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pwm !== 1'b0) begin
            $display("FAIL reset_pwm: got %b want 0", pwm); bad++;
        end
        total++;
        if (bus_if.rd_data_o !== 32'h0) begin
            $display("FAIL reset_rd_data: got %h want 00000000", bus_if.rd_data_o); bad++;
        end
        rst = 1'b0;
        do_read(8'h00, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL reset_config: got %h want 00000000", d); bad++; end
        do_read(8'h04, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL reset_status: got %h want 00000000", d); bad++; end
        do_read(8'h08, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL reset_count: got %h want 00000000", d); bad++; end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bit ok;
        do_write(8'h00, {16'd1000, 16'd250});
        wait_hi(2500, ok);
        total++;
        if (!ok) begin $display("FAIL basic_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 250) begin $display("FAIL basic_hi_len: got %0d want 250", hi_len); bad++; end
        wait_lo(2500, ok);
        total++;
        if (!ok) begin $display("FAIL basic_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 750) begin $display("FAIL basic_lo_len: got %0d want 750", lo_len); bad++; end
        do_read(8'h04, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL basic_status: got %h want 00000000", d); bad++; end
    endtask

    task automatic test_update();
        logic [31:0] d;
        bit ok;
        wait_lo(2500, ok);
        repeat (50) @(posedge clk);
        #1;
        do_write(8'h00, {16'd1000, 16'd750});
        do_read(8'h04, d);
        total++;
        if (d !== 32'h2) begin $display("FAIL upd_pending: got %h want 00000002", d); bad++; end
        wait_hi(2500, ok);
        total++;
        if (!ok) begin $display("FAIL upd_old_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 250) begin $display("FAIL upd_old_hi: got %0d want 250", hi_len); bad++; end
        wait_lo(2500, ok);
        total++;
        if (!ok) begin $display("FAIL upd_old_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 750) begin $display("FAIL upd_old_lo: got %0d want 750", lo_len); bad++; end
        wait_hi(2500, ok);
        total++;
        if (!ok) begin $display("FAIL upd_new_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 750) begin $display("FAIL upd_new_hi: got %0d want 750", hi_len); bad++; end
        wait_lo(2500, ok);
        total++;
        if (!ok) begin $display("FAIL upd_new_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 250) begin $display("FAIL upd_new_lo: got %0d want 250", lo_len); bad++; end
    endtask

    task automatic test_reject();
        logic [31:0] d;
        bit ok;
        do_write(8'h00, {16'd400, 16'd700});
        do_read(8'h04, d);
        total++;
        if (d !== 32'h1) begin $display("FAIL rej_status: got %h want 00000001", d); bad++; end
        @(posedge clk); #1;
        total++;
        if (bus_if.rd_data_o !== 32'h1) begin
            $display("FAIL rej_rd_hold: got %h want 00000001", bus_if.rd_data_o); bad++;
        end
        do_read(8'h00, d);
        total++;
        if (d !== {16'd1000, 16'd750}) begin $display("FAIL rej_config: got %h want 03e802ee", d); bad++; end
        wait_hi(2500, ok);
        total++;
        if (!ok) begin $display("FAIL rej_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 750) begin $display("FAIL rej_hi: got %0d want 750", hi_len); bad++; end
        wait_lo(2500, ok);
        total++;
        if (!ok) begin $display("FAIL rej_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 250) begin $display("FAIL rej_lo: got %0d want 250", lo_len); bad++; end
    endtask

    task automatic test_zero_period();
        logic [31:0] d;
        int high_cycles;
        do_write(8'h00, 32'h0);
        do_read(8'h04, d);
        total++;
        if (d !== 32'h2) begin $display("FAIL zero_status_pend: got %h want 00000002", d); bad++; end
        repeat (1010) @(posedge clk);
        #1;
        total++;
        if (pwm !== 1'b0) begin $display("FAIL zero_pwm: got %b want 0", pwm); bad++; end
        do_read(8'h08, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL zero_count: got %h want 00000000", d); bad++; end
        do_read(8'h04, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL zero_status: got %h want 00000000", d); bad++; end
        do_write(8'h00, {16'd10, 16'd10});
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (pwm !== 1'b1) begin $display("FAIL full_duty_start: got %b want 1", pwm); bad++; end
        high_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (pwm === 1'b1) high_cycles++;
        end
        total++;
        if (high_cycles != 30) begin $display("FAIL full_duty_hold: got %0d want 30", high_cycles); bad++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bit ok;
        bus_if.addr_i    = 8'h00;
        bus_if.wr_data_i = {16'd20, 16'd5};
        bus_if.wr_en_i   = 1'b1;
        bus_if.rd_en_i   = 1'b1;
        @(posedge clk); #1;
        bus_if.wr_en_i   = 1'b0;
        bus_if.rd_en_i   = 1'b0;
        total++;
        if (bus_if.rd_data_o !== {16'd10, 16'd10}) begin
            $display("FAIL rw_same_cycle: got %h want 000a000a", bus_if.rd_data_o); bad++;
        end
        do_read(8'h00, d);
        total++;
        if (d !== {16'd20, 16'd5}) begin $display("FAIL rw_after: got %h want 00140005", d); bad++; end
        do_write(8'h04, 32'hFFFF_FFFF);
        do_write(8'h08, 32'hFFFF_FFFF);
        do_write(8'h10, 32'hFFFF_FFFF);
        repeat (20) @(posedge clk);
        #1;
        do_read(8'h00, d);
        total++;
        if (d !== {16'd20, 16'd5}) begin $display("FAIL unmapped_wr_cfg: got %h want 00140005", d); bad++; end
        do_read(8'h04, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL unmapped_wr_status: got %h want 00000000", d); bad++; end
        do_read(8'h10, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL unmapped_rd: got %h want 00000000", d); bad++; end
        wait_hi(200, ok);
        total++;
        if (!ok) begin $display("FAIL b2b_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 5) begin $display("FAIL b2b_hi: got %0d want 5", hi_len); bad++; end
        wait_lo(200, ok);
        total++;
        if (!ok) begin $display("FAIL b2b_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 15) begin $display("FAIL b2b_lo: got %0d want 15", lo_len); bad++; end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int high_cycles;
        do_read(8'h00, d);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (pwm !== 1'b0) begin $display("FAIL rstmid_pwm: got %b want 0", pwm); bad++; end
        total++;
        if (bus_if.rd_data_o !== 32'h0) begin
            $display("FAIL rstmid_rd_data: got %h want 00000000", bus_if.rd_data_o); bad++;
        end
        do_read(8'h00, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL rstmid_config: got %h want 00000000", d); bad++; end
        do_read(8'h08, d);
        total++;
        if (d !== 32'h0) begin $display("FAIL rstmid_count: got %h want 00000000", d); bad++; end
        high_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (pwm !== 1'b0) high_cycles++;
        end
        total++;
        if (high_cycles != 0) begin $display("FAIL rstmid_stays_low: got %0d want 0", high_cycles); bad++; end
    endtask

    task automatic test_polarity();
        logic [31:0] d;
        bit ok;
        do_write(8'h0C, 32'h1);
        do_read(8'h0C, d);
`ifdef PWM_ALT_POLARITY_EN
        total++;
        if (d !== 32'h1) begin $display("FAIL pol_read: got %h want 00000001", d); bad++; end
        do_write(8'h00, {16'd1000, 16'd250});
        repeat (300) @(posedge clk);
        #1;
        wait_hi(2500, ok);
        total++;
        if (!ok) begin $display("FAIL pol_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 750) begin $display("FAIL pol_hi: got %0d want 750", hi_len); bad++; end
        wait_lo(2500, ok);
        total++;
        if (!ok) begin $display("FAIL pol_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 250) begin $display("FAIL pol_lo: got %0d want 250", lo_len); bad++; end
`else
        total++;
        if (d !== 32'h0) begin $display("FAIL pol_unmapped_read: got %h want 00000000", d); bad++; end
        do_write(8'h00, {16'd1000, 16'd250});
        repeat (300) @(posedge clk);
        #1;
        wait_lo(2500, ok);
        total++;
        if (!ok) begin $display("FAIL pol_lo_timeout: got none want low run"); bad++; end
        else if (lo_len != 750) begin $display("FAIL pol_lo: got %0d want 750", lo_len); bad++; end
        wait_hi(2500, ok);
        total++;
        if (!ok) begin $display("FAIL pol_hi_timeout: got none want high run"); bad++; end
        else if (hi_len != 250) begin $display("FAIL pol_hi: got %0d want 250", hi_len); bad++; end
`endif
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mon_run  = 0;
        mon_prev = 1'b0;
        hi_len   = 0;
        lo_len   = 0;
        hi_done  = 0;
        lo_done  = 0;
        rst      = 1'b1;
        bus_if.addr_i    = '0;
        bus_if.wr_data_i = '0;
        bus_if.wr_en_i   = 1'b0;
        bus_if.rd_en_i   = 1'b0;
        test_reset();
        test_basic();
        test_update();
        test_reject();
        test_zero_period();
        test_back_to_back();
        test_reset_mid();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
